// File: rtl/div_pkg.sv
// Shared definitions for the divided-clock ratio monitor.
// Holds the FSM state encoding, default period/timeout values and a saturating helper.
// No logic or latency of its own.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned WINDOW_PERIODS_DEF = 10;
  localparam int unsigned SHORT_PERIOD_DEF   = 8;
  localparam int unsigned LONG_PERIOD_DEF    = 9;
  localparam int unsigned TIMEOUT_DEF        = 32;

  // 8-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus edge-detect register producing a one-cycle rise pulse.
// Latency: a level sampled at edge k shows up as rise during the cycle after edge k+1.
// No backpressure: rise is a free-running pulse.
module sync_rise_det (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next values: shift the asynchronous input down the chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer and edge-detect registers, cleared by synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/div_ratio_monitor.sv
// Measures WINDOW_PERIODS periods of clk_div and classifies each as short, long or bad.
// Latency: results valid on the done pulse; rise events lag clk_div by the synchronizer.
// No backpressure: start is ignored while busy or in DONE; results hold until next start.
module div_ratio_monitor
  import div_pkg::*;
#(
  parameter int unsigned WINDOW_PERIODS = WINDOW_PERIODS_DEF,
  parameter int unsigned SHORT_PERIOD   = SHORT_PERIOD_DEF,
  parameter int unsigned LONG_PERIOD    = LONG_PERIOD_DEF,
  parameter int unsigned TIMEOUT        = TIMEOUT_DEF
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clk_div,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cnt_short,
  output logic [7:0]  cnt_long,
  output logic [15:0] total_cycles,
  output logic        err,
  output logic [7:0]  err_period
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SHORT_P8 = 8'(SHORT_PERIOD);
  localparam logic [7:0]    LONG_P8  = 8'(LONG_PERIOD);
  localparam logic [7:0]    WIN_LAST = 8'(WINDOW_PERIODS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic rise;

  sync_rise_det u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (clk_div),
    .rise   (rise)
  );

  state_t        state_q, state_d;
  logic [7:0]    per_q, per_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    ncl_q, ncl_d;
  logic [7:0]    cs_q, cs_d;
  logic [7:0]    cl_q, cl_d;
  logic [15:0]   tot_q, tot_d;
  logic          err_q, err_d;
  logic [7:0]    ep_q, ep_d;
  logic [16:0]   sum;

  // Next-state and datapath: run control, period counting, classification, timeout.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    to_d    = to_q;
    ncl_d   = ncl_q;
    cs_d    = cs_q;
    cl_d    = cl_q;
    tot_d   = tot_q;
    err_d   = err_q;
    ep_d    = ep_q;
    sum     = {1'b0, tot_q} + {9'd0, per_q};

    unique case (state_q)
      ST_IDLE: begin
        // A rise coinciding with start is deliberately dropped here.
        if (start) begin
          per_d   = 8'd0;
          to_d    = '0;
          ncl_d   = 8'd0;
          cs_d    = 8'd0;
          cl_d    = 8'd0;
          tot_d   = 16'd0;
          err_d   = 1'b0;
          ep_d    = 8'd0;
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        // The arming edge only opens the first period.
        if (rise) begin
          per_d   = 8'd1;
          to_d    = '0;
          state_d = ST_MEASURE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          ep_d    = 8'd0;
          state_d = ST_DONE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      ST_MEASURE: begin
        // A rise closes a period and wins over a coincident timeout.
        if (rise) begin
          per_d = 8'd1;
          to_d  = '0;
          ncl_d = ncl_q + 8'd1;
          tot_d = sum[16] ? 16'hFFFF : sum[15:0];
          if (per_q == SHORT_P8) begin
            cs_d = sat_inc8(cs_q);
          end else if (per_q == LONG_P8) begin
            cl_d = sat_inc8(cl_q);
          end else if (!err_q) begin
            err_d = 1'b1;
            ep_d  = per_q;
          end
          if (ncl_q == WIN_LAST) begin
            state_d = ST_DONE;
          end
        end else begin
          per_d = sat_inc8(per_q);
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            ep_d    = 8'd0;
            state_d = ST_DONE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      per_q   <= 8'd0;
      to_q    <= '0;
      ncl_q   <= 8'd0;
      cs_q    <= 8'd0;
      cl_q    <= 8'd0;
      tot_q   <= 16'd0;
      err_q   <= 1'b0;
      ep_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      to_q    <= to_d;
      ncl_q   <= ncl_d;
      cs_q    <= cs_d;
      cl_q    <= cl_d;
      tot_q   <= tot_d;
      err_q   <= err_d;
      ep_q    <= ep_d;
    end
  end

  assign busy         = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign done         = (state_q == ST_DONE);
  assign cnt_short    = cs_q;
  assign cnt_long     = cl_q;
  assign total_cycles = tot_q;
  assign err          = err_q;
  assign err_period   = ep_q;

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Bench for div_ratio_monitor: directed and random clk_div period patterns.
// Expected results come from a list-of-periods reference model.
// clk_div is replayed from a queue of period lengths by a generator process.
module tb_div_ratio_monitor;

  localparam int WIN   = 10;
  localparam int SHORT = 8;
  localparam int LONG  = 9;
  localparam int TMO   = 32;

  logic        clk_in;
  logic        rst;
  logic        clk_div;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  cnt_short;
  logic [7:0]  cnt_long;
  logic [15:0] total_cycles;
  logic        err;
  logic [7:0]  err_period;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int gen_q[$];
  int gen_p;
  int pat[$];

  typedef struct packed {
    logic [7:0]  cs;
    logic [7:0]  cl;
    logic [15:0] tot;
    logic        err;
    logic [7:0]  ep;
  } exp_t;

  div_ratio_monitor #(
    .WINDOW_PERIODS (WIN),
    .SHORT_PERIOD   (SHORT),
    .LONG_PERIOD    (LONG),
    .TIMEOUT        (TMO)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .clk_div      (clk_div),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .cnt_short    (cnt_short),
    .cnt_long     (cnt_long),
    .total_cycles (total_cycles),
    .err          (err),
    .err_period   (err_period)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Each queued period starts with a rising edge of clk_div.
  initial begin
    clk_div = 1'b0;
    forever begin
      @(negedge clk_in);
      if (gen_q.size() > 0) begin
        gen_p = gen_q.pop_front();
        clk_div = 1'b1;
        repeat (gen_p / 2) @(negedge clk_in);
        clk_div = 1'b0;
        repeat (gen_p - gen_p / 2 - 1) @(negedge clk_in);
      end
    end
  end

  always @(negedge clk_in) begin
    if (done === 1'b1) done_cnt++;
  end

  function automatic exp_t ref_model(input int ps[$]);
    exp_t e;
    int   tot;
    e   = '0;
    tot = 0;
    for (int i = 0; i < WIN && i < ps.size(); i++) begin
      if (ps[i] == SHORT) begin
        if (e.cs != 8'hFF) e.cs = e.cs + 8'd1;
      end else if (ps[i] == LONG) begin
        if (e.cl != 8'hFF) e.cl = e.cl + 8'd1;
      end else if (!e.err) begin
        e.err = 1'b1;
        e.ep  = 8'(ps[i]);
      end
      tot += ps[i];
    end
    e.tot = (tot > 65535) ? 16'hFFFF : 16'(tot);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk_in);
      cyc++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (gen_q.size() > 0 && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    repeat (12) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic do_run(input string tag, input int ps[$], input bit mid_start);
    exp_t e;
    int   cyc;
    int   d0;
    bit   ok;
    e  = ref_model(ps);
    d0 = done_cnt;
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    foreach (ps[i]) gen_q.push_back(ps[i]);
    gen_q.push_back(8);
    if (mid_start) begin
      repeat (30) @(negedge clk_in);
      pulse_start();
    end
    wait_done(400, cyc, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    wait_idle();
    chk({tag, "_cnt_short"}, 32'(cnt_short), 32'(e.cs));
    chk({tag, "_cnt_long"}, 32'(cnt_long), 32'(e.cl));
    chk({tag, "_total"}, 32'(total_cycles), 32'(e.tot));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    chk({tag, "_err_period"}, 32'(err_period), 32'(e.ep));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic build_87();
    pat.delete();
    repeat (3) pat.push_back(8);
    repeat (7) pat.push_back(9);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    int  d0;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outputs", {cnt_short, cnt_long, total_cycles}, 32'd0);
    chk("reset_err", {23'd0, err, err_period}, 32'd0);

    // Nominal 8.7 pattern.
    build_87();
    do_run("p87", pat, 1'b0);

    // Timeout with clk_div held low; a start during DONE must be ignored.
    pulse_start();
    wait_done(100, cyc, ok);
    chk("tmo_done_seen", 32'(ok), 32'd1);
    chk("tmo_cycles", 32'(cyc), 32'(TMO));
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    chk("tmo_start_in_done_ignored", 32'(busy), 32'd0);
    repeat (3) @(negedge clk_in);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_err_period", 32'(err_period), 32'd0);
    chk("tmo_cnt_short", 32'(cnt_short), 32'd0);
    chk("tmo_cnt_long", 32'(cnt_long), 32'd0);

    // One bad period of 10 among nine 9s.
    pat.delete();
    repeat (4) pat.push_back(9);
    pat.push_back(10);
    repeat (5) pat.push_back(9);
    do_run("bad10", pat, 1'b0);
    chk("bad10_total_91", 32'(total_cycles), 32'd91);

    // Second start mid-MEASURE is ignored.
    build_87();
    do_run("midstart", pat, 1'b1);

    // Reset mid-MEASURE aborts without done.
    build_87();
    d0 = done_cnt;
    pulse_start();
    foreach (pat[i]) gen_q.push_back(pat[i]);
    gen_q.push_back(8);
    repeat (40) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_counts", {cnt_short, cnt_long, total_cycles}, 32'd0);
    chk("rst_err", {23'd0, err, err_period}, 32'd0);
    wait_idle();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_still_idle", 32'(busy), 32'd0);
    build_87();
    do_run("after_rst", pat, 1'b0);

    // Random period mixes around the nominal values.
    for (int r = 0; r < 5; r++) begin
      pat.delete();
      for (int k = 0; k < WIN; k++) pat.push_back(int'($urandom_range(7, 10)));
      do_run($sformatf("rnd%0d", r), pat, (r == 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
